systemizer_seq_ctrl: RTL

- Sequencer that owns the systemizer matrix engine for one complete job: load, run, then drain.
- Load: streams a host matrix into the systemizer word memory.
- Run: launches the left phase, then the right phase (start_right), and monitors done/fail.
- Drain: streams the systemized matrix back to the host.
- Sits between the chip-level pin wrapper and the systemizer instance, replacing hard-wired rd/wr tie-offs.

---
 rtl/systemizer_seq_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/systemizer_seq_ctrl.sv
// Job sequencer for the systemizer engine: load the host matrix, run the left then right phase, drain the result.
// Optional watchdog on the WAIT states is compiled in with SYS_TIMEOUT_EN.
module systemizer_seq_ctrl #(
    parameter int L       = 8,
    parameter int K       = 16,
    parameter int M       = 3,
    parameter int BLOCK   = 4,
    parameter int TIMEOUT = 4096,
    localparam int EW     = $clog2(M),
    localparam int DW     = BLOCK * EW,
    localparam int WORDS  = (L * K) / BLOCK,
    localparam int AW     = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          job_done,
    output logic          job_fail,
    output logic          job_timeout,
    output logic          sys_start,
    output logic          sys_start_right,
    input  logic          sys_done,
    input  logic          sys_fail,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [DW-1:0] sys_data_in,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [DW-1:0] sys_data_out
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START_L, WAIT_L, START_R, WAIT_R, DRAIN, FIN
    } state_t;

    // One extra bit so a power-of-two WORDS reaches the terminal count without wrapping.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(WORDS - 1);
    localparam logic [CW-1:0] WORDS_CNT = CW'(WORDS);

    state_t          state_q, state_d;
    logic [CW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   raddr_q, raddr_d;
    logic            rd_pend_q, rd_pend_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            job_fail_q, job_fail_d;
    logic            job_timeout_q, job_timeout_d;
    logic            timeout_hit;
    logic            in_wait;

    assign in_wait = (state_q == WAIT_L) || (state_q == WAIT_R);

`ifdef SYS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_q, tmo_d;

    // Counter is held at zero outside the WAIT states, so each WAIT entry starts fresh.
    always_comb begin
        tmo_d = '0;
        if (in_wait) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign timeout_hit = in_wait && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        raddr_d         = raddr_q;
        rd_pend_d       = 1'b0;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        job_fail_d      = job_fail_q;
        job_timeout_d   = job_timeout_q;
        in_ready        = 1'b0;
        sys_wr_en       = 1'b0;
        sys_rd_en       = 1'b0;
        sys_start       = 1'b0;
        sys_start_right = 1'b0;
        job_done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    job_fail_d    = 1'b0;
                    job_timeout_d = 1'b0;
                    addr_d        = '0;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sys_wr_en = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = START_L;
                    end
                end
            end
            START_L: begin
                sys_start = 1'b1;
                state_d   = WAIT_L;
            end
            WAIT_L: begin
                if (sys_done) begin
                    if (sys_fail) begin
                        job_fail_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        state_d = START_R;
                    end
                end else if (timeout_hit) begin
                    job_fail_d    = 1'b1;
                    job_timeout_d = 1'b1;
                    state_d       = FIN;
                end
            end
            START_R: begin
                sys_start_right = 1'b1;
                state_d         = WAIT_R;
            end
            WAIT_R: begin
                if (sys_done) begin
                    if (sys_fail) begin
                        job_fail_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        raddr_d = '0;
                        state_d = DRAIN;
                    end
                end else if (timeout_hit) begin
                    job_fail_d    = 1'b1;
                    job_timeout_d = 1'b1;
                    state_d       = FIN;
                end
            end
            DRAIN: begin
                // Read only when the single output slot is guaranteed free on the data-return cycle.
                if ((!out_valid_q || out_ready) && !rd_pend_q && (raddr_q < WORDS_CNT)) begin
                    sys_rd_en = 1'b1;
                    raddr_d   = raddr_q + 1'b1;
                    rd_pend_d = 1'b1;
                end
                if (out_valid_q && out_ready && !rd_pend_q && (raddr_q == WORDS_CNT)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                job_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rd_pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = sys_data_out;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            raddr_q       <= '0;
            rd_pend_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            job_fail_q    <= 1'b0;
            job_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            raddr_q       <= raddr_d;
            rd_pend_q     <= rd_pend_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            job_fail_q    <= job_fail_d;
            job_timeout_q <= job_timeout_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign job_fail    = job_fail_q;
    assign job_timeout = job_timeout_q;
    assign sys_wr_addr = addr_q[AW-1:0];
    assign sys_data_in = in_data;
    assign sys_rd_addr = raddr_q[AW-1:0];

endmodule
